// File: rtl/spram_bank_arbiter.sv
// spram_bank_arbiter: two-requester round-robin arbiter and zero-initialiser for a banked single-port RAM array.
// Latency: grant and array access are combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: requests are held until granted; no grants during the zero sweep, nor to another bank while a read returns.
module spram_bank_arbiter #(
    parameter  int AWIDTH = 12,
    parameter  int DWIDTH = 9,
    parameter  int NBANKS = 2,
    localparam int IWIDTH = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic              clock0,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              init_done,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [IWIDTH-1:0] a_id,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DWIDTH-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [IWIDTH-1:0] b_id,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] b_rdata,

    output logic              mem_rce,
    output logic [AWIDTH-1:0] mem_ra,
    output logic              mem_wce,
    output logic [AWIDTH-1:0] mem_wa,
    output logic [DWIDTH-1:0] mem_wd,
    output logic [IWIDTH-1:0] mem_id,
    input  logic [DWIDTH-1:0] mem_rq
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_e;

    localparam logic [IWIDTH-1:0] BANK_LAST = IWIDTH'(NBANKS - 1);

    state_e            state_q,    state_d;
    logic [IWIDTH-1:0] clr_bank_q, clr_bank_d;
    logic [AWIDTH-1:0] clr_addr_q, clr_addr_d;
    logic              last_b_q,   last_b_d;    // 1: B won the most recent grant
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [IWIDTH-1:0] rd_id_q,    rd_id_d;     // bank of the read whose data returns this cycle

    logic rd_pend;
    logic a_ok;
    logic b_ok;
    logic arb_a;
    logic arb_b;
    logic clr_stall;

    // The array muxes its registered read data by mem_id, so while a read
    // returns only an access to the same bank may be issued alongside it.
    assign rd_pend = a_rvalid_q | b_rvalid_q;
    assign a_ok    = a_req & (~rd_pend | (a_id == rd_id_q));
    assign b_ok    = b_req & (~rd_pend | (b_id == rd_id_q));

    // On a conflict the requester that did not win last time goes first.
    assign arb_a   = a_ok & (~b_ok | last_b_q);
    assign arb_b   = b_ok & ~arb_a;

    // A read granted in the same cycle as clr_start may return on another
    // bank than the sweep is at; hold the sweep write for that one cycle.
    assign clr_stall = rd_pend & (rd_id_q != clr_bank_q);

    assign init_done = (state_q == ST_ARB);
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rvalid_q ? mem_rq : '0;
    assign b_rdata   = b_rvalid_q ? mem_rq : '0;

    // State, sweep counters, round-robin pointer and read-return tracking.
    always_ff @(posedge clock0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_bank_q <= '0;
            clr_addr_q <= '0;
            last_b_q   <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_bank_q <= clr_bank_d;
            clr_addr_q <= clr_addr_d;
            last_b_q   <= last_b_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    // Next state: sweep advance and exit, clr_start restart, grant bookkeeping.
    always_comb begin
        state_d    = state_q;
        clr_bank_d = clr_bank_q;
        clr_addr_d = clr_addr_q;
        last_b_d   = last_b_q;
        a_rvalid_d = a_gnt & ~a_we;
        b_rvalid_d = b_gnt & ~b_we;
        rd_id_d    = rd_id_q;

        if (a_gnt & ~a_we) begin
            rd_id_d = a_id;
        end else if (b_gnt & ~b_we) begin
            rd_id_d = b_id;
        end

        if (a_gnt) begin
            last_b_d = 1'b0;
        end else if (b_gnt) begin
            last_b_d = 1'b1;
        end

        case (state_q)
            ST_CLEAR: begin
                if (clr_start) begin
                    clr_bank_d = '0;
                    clr_addr_d = '0;
                end else if (!clr_stall) begin
                    clr_addr_d = clr_addr_q + AWIDTH'(1);
                    if (clr_addr_q == '1) begin
                        if (clr_bank_q == BANK_LAST) begin
                            state_d    = ST_ARB;
                            clr_bank_d = '0;
                        end else begin
                            clr_bank_d = clr_bank_q + IWIDTH'(1);
                        end
                    end
                end
            end
            ST_ARB: begin
                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    clr_bank_d = '0;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Outputs: sweep writes in CLEAR, granted access in ARB, all quiet in reset.
    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        mem_rce = 1'b0;
        mem_ra  = '0;
        mem_wce = 1'b0;
        mem_wa  = '0;
        mem_wd  = '0;
        mem_id  = rd_id_q;

        if (rst_n) begin
            case (state_q)
                ST_CLEAR: begin
                    if (!clr_stall) begin
                        mem_wce = 1'b1;
                        mem_wa  = clr_addr_q;
                        mem_id  = clr_bank_q;
                    end
                end
                ST_ARB: begin
                    a_gnt = arb_a;
                    b_gnt = arb_b;
                    if (arb_a) begin
                        mem_id = a_id;
                        if (a_we) begin
                            mem_wce = 1'b1;
                            mem_wa  = a_addr;
                            mem_wd  = a_wdata;
                        end else begin
                            mem_rce = 1'b1;
                            mem_ra  = a_addr;
                        end
                    end else if (arb_b) begin
                        mem_id = b_id;
                        if (b_we) begin
                            mem_wce = 1'b1;
                            mem_wa  = b_addr;
                            mem_wd  = b_wdata;
                        end else begin
                            mem_rce = 1'b1;
                            mem_ra  = b_addr;
                        end
                    end
                end
                default: begin
                    a_gnt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_bank_arbiter.sv
// tb_spram_bank_arbiter: directed bench with a banked RAM array model and a cycle-level behavioural scoreboard.
// Latency: outputs compared every negedge; inputs driven 1 time unit after each rising edge.
// Backpressure: requesters hold req until the combinational grant is observed, with bounded waits.
module tb_spram_bank_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 9;
    localparam int NB    = 2;
    localparam int IW    = 1;
    localparam int WORDS = 1 << AW;
    localparam int SWEEP = NB * WORDS;

    logic          clock0 = 1'b0;
    logic          rst_n;
    logic          clr_start = 1'b0;
    logic          init_done;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [IW-1:0] a_id = '0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_gnt, a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [IW-1:0] b_id = '0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_gnt, b_rvalid;
    logic [DW-1:0] b_rdata;
    logic          mem_rce, mem_wce;
    logic [AW-1:0] mem_ra, mem_wa;
    logic [DW-1:0] mem_wd, mem_rq;
    logic [IW-1:0] mem_id;

    int n_vec = 0;
    int n_err = 0;

    spram_bank_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NBANKS(NB)) dut (
        .clock0(clock0), .rst_n(rst_n), .clr_start(clr_start), .init_done(init_done),
        .a_req(a_req), .a_we(a_we), .a_id(a_id), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_id(b_id), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_rce(mem_rce), .mem_ra(mem_ra), .mem_wce(mem_wce), .mem_wa(mem_wa),
        .mem_wd(mem_wd), .mem_id(mem_id), .mem_rq(mem_rq)
    );

    always #5 clock0 = ~clock0;

    // Physical array: per-bank registered read output, muxed by mem_id.
    logic [DW-1:0] arr   [NB][WORDS];
    logic [DW-1:0] arr_q [NB];
    initial begin
        for (int bk = 0; bk < NB; bk++)
            for (int w = 0; w < WORDS; w++)
                arr[bk][w] = 9'h1FF;
    end
    always @(posedge clock0) begin
        if (mem_wce) arr[mem_id][mem_wa] <= mem_wd;
        if (mem_rce) arr_q[mem_id] <= arr[mem_id][mem_ra];
    end
    assign mem_rq = arr_q[mem_id];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: linear sweep index, word-level memory image, one pending read.
    logic [DW-1:0] mm [NB][WORDS];
    bit            m_clear;
    int            m_k;
    bit            m_lw_b;
    bit            m_pend, m_pend_a;
    int            m_pend_id;
    logic [DW-1:0] m_pend_dat;

    always @(negedge clock0) begin : compare
        bit a_ok, b_ok, ea, eb, we, adv;
        int bank, id, addr;
        logic [DW-1:0] wd;
        if (!rst_n) begin
            chk("rst_init_done", init_done, 0);
            chk("rst_a_gnt", a_gnt, 0);
            chk("rst_b_gnt", b_gnt, 0);
            chk("rst_a_rvalid", a_rvalid, 0);
            chk("rst_b_rvalid", b_rvalid, 0);
            chk("rst_mem_wce", mem_wce, 0);
            chk("rst_mem_rce", mem_rce, 0);
            m_clear = 1; m_k = 0; m_lw_b = 1; m_pend = 0;
        end else begin
            chk("init_done", init_done, !m_clear);
            chk("a_rvalid", a_rvalid, m_pend && m_pend_a);
            chk("b_rvalid", b_rvalid, m_pend && !m_pend_a);
            if (m_pend && m_pend_a)  chk("a_rdata", a_rdata, m_pend_dat);
            if (m_pend && !m_pend_a) chk("b_rdata", b_rdata, m_pend_dat);
            if (m_clear) begin
                bank = m_k / WORDS;
                chk("clr_a_gnt", a_gnt, 0);
                chk("clr_b_gnt", b_gnt, 0);
                chk("clr_mem_rce", mem_rce, 0);
                if (m_pend && m_pend_id != bank) begin
                    chk("clr_hold_wce", mem_wce, 0);
                    chk("clr_hold_id", mem_id, m_pend_id);
                    adv = 0;
                end else begin
                    chk("clr_mem_wce", mem_wce, 1);
                    chk("clr_mem_wa", mem_wa, m_k % WORDS);
                    chk("clr_mem_id", mem_id, bank);
                    chk("clr_mem_wd", mem_wd, 0);
                    mm[bank][m_k % WORDS] = '0;
                    adv = 1;
                end
                m_pend = 0;
                if (clr_start) begin
                    m_k = 0;
                end else if (adv) begin
                    m_k++;
                    if (m_k == SWEEP) begin
                        m_clear = 0;
                        m_k = 0;
                    end
                end
            end else begin
                a_ok = a_req && (!m_pend || int'(a_id) == m_pend_id);
                b_ok = b_req && (!m_pend || int'(b_id) == m_pend_id);
                if (a_ok && b_ok) begin
                    ea = m_lw_b; eb = !m_lw_b;
                end else begin
                    ea = a_ok; eb = b_ok;
                end
                chk("a_gnt", a_gnt, ea);
                chk("b_gnt", b_gnt, eb);
                if (!(ea || eb)) begin
                    chk("idle_wce", mem_wce, 0);
                    chk("idle_rce", mem_rce, 0);
                    if (m_pend) chk("ret_mem_id", mem_id, m_pend_id);
                    m_pend = 0;
                end else begin
                    we   = ea ? a_we : b_we;
                    id   = ea ? int'(a_id) : int'(b_id);
                    addr = ea ? int'(a_addr) : int'(b_addr);
                    wd   = ea ? a_wdata : b_wdata;
                    chk("mem_id", mem_id, id);
                    chk("mem_wce", mem_wce, we);
                    chk("mem_rce", mem_rce, !we);
                    if (we) begin
                        chk("mem_wa", mem_wa, addr);
                        chk("mem_wd", mem_wd, wd);
                        mm[id][addr] = wd;
                        m_pend = 0;
                    end else begin
                        chk("mem_ra", mem_ra, addr);
                        m_pend = 1; m_pend_a = ea; m_pend_id = id;
                        m_pend_dat = mm[id][addr];
                    end
                    m_lw_b = eb;
                end
                if (clr_start) begin
                    m_clear = 1;
                    m_k = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock0);
        #1;
    endtask

    task automatic wait_gnt(input bit is_b, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock0);
            if (is_b ? b_gnt : a_gnt) begin
                ok = 1;
                break;
            end
        end
    endtask

    // One access; returns aligned just after a rising edge.
    task automatic access(input bit is_b, input bit we, input logic [IW-1:0] id,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd);
        bit ok;
        rd = 'x;
        if (is_b) begin
            b_req = 1; b_we = we; b_id = id; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1; a_we = we; a_id = id; a_addr = addr; a_wdata = wd;
        end
        wait_gnt(is_b, ok);
        chk("gnt_wait", ok, 1);
        step();
        if (is_b) b_req = 0; else a_req = 0;
        if (!we) begin
            @(negedge clock0);
            chk("own_rvalid", is_b ? b_rvalid : a_rvalid, 1);
            chk("other_rvalid", is_b ? a_rvalid : b_rvalid, 0);
            rd = is_b ? b_rdata : a_rdata;
            step();
        end
    endtask

    // Count sweep cycles until init_done rises; checks first and last written location.
    task automatic count_sweep(input int first_k, output int n);
        int last_wa, last_id;
        n = 0; last_wa = -1; last_id = -1;
        for (int i = 0; i < SWEEP + 100; i++) begin
            @(negedge clock0);
            if (init_done) break;
            if (i == 0) begin
                chk("sweep_first_wa", mem_wa, first_k % WORDS);
                chk("sweep_first_id", mem_id, first_k / WORDS);
            end
            if (mem_wce) begin
                last_wa = int'(mem_wa);
                last_id = int'(mem_id);
            end
            n++;
        end
        chk("sweep_last_wa", last_wa, WORDS - 1);
        chk("sweep_last_id", last_id, NB - 1);
        step();
    endtask

    logic [DW-1:0] rd;
    int            n;
    string         who_s;
    int            who, prev;

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Power-up sweep, then every word reads as zero.
        count_sweep(0, n);
        chk("sweep_len", n, SWEEP);
        access(0, 0, 1'b0, 12'h777, '0, rd);
        chk("rd_after_sweep", rd, 0);

        // Write then read back-to-back.
        access(0, 1, 1'b1, 12'h123, 9'h1A5, rd);
        access(0, 0, 1'b1, 12'h123, '0, rd);
        chk("rd_1a5", rd, 9'h1A5);

        // Preload; B last so A wins the next conflict.
        access(0, 1, 1'b1, 12'h010, 9'h0AA, rd);
        access(1, 1, 1'b0, 12'h030, 9'h0CC, rd);
        access(0, 1, 1'b0, 12'h005, 9'h055, rd);
        access(1, 1, 1'b1, 12'h020, 9'h0BB, rd);

        // Both requesters read the same bank every cycle.
        a_req = 1; a_we = 0; a_id = 1'b1; a_addr = 12'h010;
        b_req = 1; b_we = 0; b_id = 1'b1; b_addr = 12'h020;
        prev = 2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock0);
            who = a_gnt ? 0 : (b_gnt ? 1 : 2);
            chk($sformatf("alt_gnt_%0d", i), who, i % 2);
            if (prev == 0) begin
                chk("alt_a_rvalid", a_rvalid, 1);
                chk("alt_a_rdata", a_rdata, 9'h0AA);
            end else if (prev == 1) begin
                chk("alt_b_rvalid", b_rvalid, 1);
                chk("alt_b_rdata", b_rdata, 9'h0BB);
            end
            prev = who;
            step();
        end
        a_req = 0; b_req = 0;
        @(negedge clock0);
        chk("alt_last_b_rvalid", b_rvalid, 1);
        chk("alt_last_b_rdata", b_rdata, 9'h0BB);
        step();

        // Cross-bank request stalls while a read returns.
        b_req = 1; b_we = 0; b_id = 1'b0; b_addr = 12'h030;
        @(negedge clock0);
        chk("stall_b_gnt", b_gnt, 1);
        step();
        b_req = 0;
        a_req = 1; a_we = 0; a_id = 1'b1; a_addr = 12'h123;
        @(negedge clock0);
        chk("stall_a_gnt", a_gnt, 0);
        chk("stall_b_rvalid", b_rvalid, 1);
        chk("stall_b_rdata", b_rdata, 9'h0CC);
        chk("stall_mem_id", mem_id, 0);
        step();
        @(negedge clock0);
        chk("stall_a_gnt_late", a_gnt, 1);
        step();
        a_req = 0;
        @(negedge clock0);
        chk("stall_a_rvalid", a_rvalid, 1);
        chk("stall_a_rdata", a_rdata, 9'h1A5);
        step();

        // clr_start in the same cycle as a read grant.
        a_req = 1; a_we = 0; a_id = 1'b0; a_addr = 12'h005;
        clr_start = 1;
        @(negedge clock0);
        chk("clr_a_gnt", a_gnt, 1);
        step();
        a_req = 0; clr_start = 0;
        @(negedge clock0);
        chk("clr_a_rvalid", a_rvalid, 1);
        chk("clr_a_rdata", a_rdata, 9'h055);
        chk("clr_init_done", init_done, 0);
        count_sweep(1, n);
        chk("clr_sweep_len", n + 1, SWEEP);
        access(0, 0, 1'b1, 12'h123, '0, rd);
        chk("rd_cleared", rd, 0);

        // Reset in the middle of a sweep.
        clr_start = 1;
        step();
        clr_start = 0;
        repeat (3000) step();
        rst_n = 0;
        @(negedge clock0);
        chk("midrst_wce", mem_wce, 0);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_a_gnt", a_gnt, 0);
        step();
        step();
        rst_n = 1;
        count_sweep(0, n);
        chk("rst_sweep_len", n, SWEEP);
        access(1, 0, 1'b1, 12'h010, '0, rd);
        chk("rd_after_rst", rd, 0);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spram_bank_arbiter.md
Name: spram_bank_arbiter

Overview:
Two-requester round-robin arbiter and initialiser for the banked 9x4096 single-port RAM array (NBANKS instances, bank chosen by id). It drives the array's clock0/rce/ra/wce/wa/wd/id port and returns read data to the requester that issued the read. After reset, and on request, it sweeps every bank and writes zero to every word before it accepts any traffic.

Parameters:
AWIDTH, 12, word address width per bank
DWIDTH, 9, data width
NBANKS, 2, number of RAM instances; IWIDTH = $clog2(NBANKS), minimum 1

Ports:
clock0  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr_start  in  1  one-cycle pulse; restarts the zero sweep
init_done  out  1  high when sweep complete and arbiter open
a_req  in  1  requester A access request, held until granted
a_we  in  1  1 = write, 0 = read
a_id  in  IWIDTH  bank select
a_addr  in  AWIDTH  word address
a_wdata  in  DWIDTH  write data
a_gnt  out  1  combinational grant; access issued this cycle
a_rvalid  out  1  read data valid for A
a_rdata  out  DWIDTH  read data for A
b_*  same set as a_* for requester B
mem_rce  out  1  array read enable
mem_ra  out  AWIDTH  array read address
mem_wce  out  1  array write enable
mem_wa  out  AWIDTH  array write address
mem_wd  out  DWIDTH  array write data
mem_id  out  IWIDTH  array bank select
mem_rq  in  DWIDTH  array read data (registered in array, 1-cycle latency)

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clr_bank=0, clr_addr=0, last_winner=B (so A wins the first conflict). init_done, a_rvalid and b_rvalid are 0, and a_gnt, b_gnt, mem_rce and mem_wce are 0 while rst_n is low.
- FSM states: CLEAR, ARB.
- CLEAR:
  - Each cycle: mem_wce=1, mem_wa=clr_addr, mem_id=clr_bank, mem_wd=0, mem_rce=0; a_gnt=b_gnt=0.
  - clr_addr increments each cycle. On wrap from 2^AWIDTH-1 it returns to 0 and clr_bank increments.
  - After the write to bank NBANKS-1, address 2^AWIDTH-1 -> ARB, and init_done goes to 1 in the same edge.
  - Sweep length is exactly NBANKS*2^AWIDTH cycles (8192 at defaults).
- ARB:
  - If only one req is high, that requester is granted.
  - If both are high, the requester that is not last_winner is granted.
  - last_winner updates to the granted requester on every grant.
  - At most one grant per cycle. No req -> no grant, and mem_rce=mem_wce=0.
- Issue (combinational in the grant cycle):
  - write: mem_wce=1, mem_wa=addr, mem_wd=wdata, mem_id=id, mem_rce=0.
  - read: mem_rce=1, mem_ra=addr, mem_id=id, mem_wce=0.
  - A requester sees gnt, then drops or changes its req at the next edge.
- Read return:
  - x_rvalid is registered; it is 1 for exactly the cycle after a read grant to x.
  - x_rdata = mem_rq, valid only while x_rvalid=1.
  - mem_id must keep the bank of the returning read during that cycle; the array muxes rq by id.
  - Therefore, while an rvalid is pending, the next grant is restricted to the same bank id. A request to a different bank stalls (gnt=0) for one cycle.
- Writes return nothing. Write then read to the same address in back-to-back grants returns the new data.
- clr_start:
  - Sampled in ARB: state -> CLEAR, counters -> 0, init_done -> 0 at the next edge.
  - A grant in that same cycle still completes, including its rvalid.
  - clr_start during CLEAR restarts the sweep from bank 0, address 0.
- Reset mid-sweep or mid-read: everything returns to reset values, the sweep restarts, and a pending rvalid is dropped.
- Address and id are passed unmodified. An id >= NBANKS is out of range: the grant is given but the access is a no-op in the array.

Test Plan:
- Release reset, idle reqs -> exactly 8192 cycles of mem_wce=1 with wd=0 covering (id,addr) (0,0)..(1,4095) in order, then init_done=1. Any read returns 0.
- After init, A writes id=1 addr=0x123 data=0x1A5, then reads it -> a_gnt each cycle, a_rvalid one cycle after the read grant, a_rdata=0x1A5, b_rvalid=0.
- A and B request reads every cycle for 6 cycles, same bank -> grants alternate A,B,A,B,A,B starting with A, and each rvalid is routed to the correct requester.
- B reads bank 0, then A requests bank 1 in the next cycle -> A stalls one cycle (a_gnt=0), b_rdata is the bank-0 data, then A is granted.
- clr_start pulsed in ARB while A reads addr 5 -> A's rvalid still arrives, init_done=0 for 8192 cycles, the previously written 0x1A5 reads back 0 afterwards.
- Assert rst_n low at sweep cycle 3000 -> outputs go to reset values immediately, and after release the full 8192-cycle sweep restarts from (0,0).
